// File: rtl/core_types_pkg.sv
// Shared core types: datapath width, memory access sizes and the LSU request record.
package core_types_pkg;

    localparam int N_BITS  = 32;
    localparam int DMEM_NB = N_BITS / 8;

    typedef enum logic [1:0] {
        MEM_B   = 2'b00,
        MEM_H   = 2'b01,
        MEM_W   = 2'b10,
        MEM_ILL = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        REQ      = 2'b01,
        WAIT_RSP = 2'b10
    } dmem_state_t;

    // Request captured in IDLE; the memory port is driven only from this record.
    typedef struct packed {
        logic                 is_store;
        mem_size_t            size;
        logic                 is_unsigned;
        logic [1:0]           off;
        logic [N_BITS-1:0]    addr;
        logic [DMEM_NB-1:0]   be;
        logic [N_BITS-1:0]    wdata;
    } dmem_req_t;

    function automatic logic dmem_misaligned(input mem_size_t sz, input logic [1:0] off);
        case (sz)
            MEM_B:   return 1'b0;
            MEM_H:   return off[0];
            MEM_W:   return |off;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ld_align.sv
// Load data alignment: shifts the addressed byte/half/word down to bit 0 and extends it.
module dmem_ld_align
    import core_types_pkg::*;
(
    input  logic [N_BITS-1:0] raw,
    input  logic [1:0]        offset,
    input  mem_size_t         size,
    input  logic              is_unsigned,
    output logic [N_BITS-1:0] ld_data
);

    logic [N_BITS-1:0] shifted;

    always_comb begin
        shifted = raw >> {offset, 3'b000};
        case (size)
            MEM_B:   ld_data = {{(N_BITS-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
            MEM_H:   ld_data = {{(N_BITS-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer: alignment check, byte-lane store generation, one transaction
// at a time over a valid/ready memory port, with the pipeline stalled until done.
module dmem_lsu_ctrl
    import core_types_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic                req_is_store,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [N_BITS-1:0]   req_addr,
    input  logic [N_BITS-1:0]   req_wdata,
    output logic                stall,
    output logic                misaligned,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_we,
    output logic [N_BITS-1:0]   mem_req_addr,
    output logic [DMEM_NB-1:0]  mem_req_be,
    output logic [N_BITS-1:0]   mem_req_wdata,
    input  logic                mem_rsp_valid,
    input  logic [N_BITS-1:0]   mem_rsp_data,
    output logic                ld_valid,
    output logic [N_BITS-1:0]   ld_data
);

    dmem_state_t       state_q, state_d;
    dmem_req_t         cap_q, cap_d, new_req;
    mem_size_t         size_in;
    logic              done;
    logic [N_BITS-1:0] align_out;

    assign size_in = mem_size_t'(req_size);

    always_comb begin
        new_req             = '0;
        new_req.is_store    = req_is_store;
        new_req.size        = size_in;
        new_req.is_unsigned = req_unsigned;
        new_req.off         = req_addr[1:0];
        new_req.addr        = {req_addr[N_BITS-1:2], 2'b00};
        case (size_in)
            MEM_B: begin
                new_req.be    = DMEM_NB'(1) << req_addr[1:0];
                new_req.wdata = {DMEM_NB{req_wdata[7:0]}};
            end
            MEM_H: begin
                new_req.be    = DMEM_NB'(3) << req_addr[1:0];
                new_req.wdata = {(DMEM_NB/2){req_wdata[15:0]}};
            end
            default: begin
                new_req.be    = '1;
                new_req.wdata = req_wdata;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        case (state_q)
            IDLE: begin
                if (req_valid && !dmem_misaligned(size_in, req_addr[1:0])) begin
                    cap_d   = new_req;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) state_d = cap_q.is_store ? IDLE : WAIT_RSP;
            end
            WAIT_RSP: begin
                if (mem_rsp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
        end
    end

    // Request side is a pure function of flops, so ready never loops back into valid.
    assign mem_req_valid = (state_q == REQ);
    assign mem_req_we    = cap_q.is_store;
    assign mem_req_addr  = cap_q.addr;
    assign mem_req_be    = cap_q.be;
    assign mem_req_wdata = cap_q.wdata;

    assign misaligned = (state_q == IDLE) && req_valid && dmem_misaligned(size_in, req_addr[1:0]);
    assign ld_valid   = (state_q == WAIT_RSP) && mem_rsp_valid;
    assign done       = ((state_q == REQ) && mem_req_ready && cap_q.is_store) || ld_valid;
    assign stall      = req_valid && !misaligned && !done;

    dmem_ld_align u_ld_align (
        .raw         (mem_rsp_data),
        .offset      (cap_q.off),
        .size        (cap_q.size),
        .is_unsigned (cap_q.is_unsigned),
        .ld_data     (align_out)
    );

    assign ld_data = ld_valid ? align_out : '0;

endmodule
